// File: rtl/ascon_block_sequencer.sv
// AEAD128 block schedule walker: AD full, AD last, data full, data last, then done pulse (macro ASCON_SEQ_ABORT_EN adds abort_i).
// Latency: first descriptor 1 cycle after start; backpressure: registered descriptor holds while blk_ready_i is low.
module ascon_block_sequencer #(
  parameter int unsigned BLOCK_AW = 8,
  parameter int unsigned PAD_AW   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [BLOCK_AW-1:0] ad_blk_no_i,
  input  logic [PAD_AW-1:0]   ad_pad_idx_i,
  input  logic                ad_empty_i,
  input  logic [BLOCK_AW-1:0] di_blk_no_i,
  input  logic [PAD_AW-1:0]   di_pad_idx_i,
`ifdef ASCON_SEQ_ABORT_EN
  input  logic                abort_i,
`endif
  input  logic                blk_ready_i,
  output logic                blk_valid_o,
  output logic                blk_is_ad_o,
  output logic                blk_last_o,
  output logic [BLOCK_AW-1:0] blk_idx_o,
  output logic [PAD_AW-1:0]   blk_pad_idx_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AD_FULL,
    S_AD_LAST,
    S_DI_FULL,
    S_DI_LAST,
    S_DONE
  } state_t;

  localparam logic [BLOCK_AW-1:0] ONE = BLOCK_AW'(1);

  state_t              state_q, state_d;
  logic [BLOCK_AW-1:0] cnt_q, cnt_d;
  logic [BLOCK_AW-1:0] ad_blk_q, di_blk_q;
  logic [PAD_AW-1:0]   ad_pad_q, di_pad_q;

  logic [BLOCK_AW-1:0] ad_blk_s, di_blk_s;
  logic [PAD_AW-1:0]   ad_pad_s, di_pad_s;
  logic                hs, abort;

  logic                vld_d, is_ad_d, last_d;
  logic [BLOCK_AW-1:0] idx_d;
  logic [PAD_AW-1:0]   pad_d;

`ifdef ASCON_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign hs = blk_valid_o & blk_ready_i;

  // Outputs are registered from state_d, so the first descriptor must see the raw sizes.
  assign ad_blk_s = (state_q == S_IDLE) ? ad_blk_no_i  : ad_blk_q;
  assign ad_pad_s = (state_q == S_IDLE) ? ad_pad_idx_i : ad_pad_q;
  assign di_blk_s = (state_q == S_IDLE) ? di_blk_no_i  : di_blk_q;
  assign di_pad_s = (state_q == S_IDLE) ? di_pad_idx_i : di_pad_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          if (ad_empty_i) state_d = (di_blk_no_i != '0) ? S_DI_FULL : S_DI_LAST;
          else            state_d = (ad_blk_no_i != '0) ? S_AD_FULL : S_AD_LAST;
        end
      end
      S_AD_FULL: begin
        if (hs) begin
          if (cnt_q == ad_blk_q - ONE) begin
            state_d = S_AD_LAST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_AD_LAST: begin
        if (hs) state_d = (di_blk_q != '0) ? S_DI_FULL : S_DI_LAST;
      end
      S_DI_FULL: begin
        if (hs) begin
          if (cnt_q == di_blk_q - ONE) begin
            state_d = S_DI_LAST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_DI_LAST: begin
        if (hs) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort beats a coincident handshake: the descriptor is dropped, not consumed.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    vld_d   = 1'b0;
    is_ad_d = 1'b0;
    last_d  = 1'b0;
    idx_d   = '0;
    pad_d   = '0;
    case (state_d)
      S_AD_FULL: begin
        vld_d   = 1'b1;
        is_ad_d = 1'b1;
        idx_d   = cnt_d;
      end
      S_AD_LAST: begin
        vld_d   = 1'b1;
        is_ad_d = 1'b1;
        last_d  = 1'b1;
        idx_d   = ad_blk_s;
        pad_d   = ad_pad_s;
      end
      S_DI_FULL: begin
        vld_d = 1'b1;
        idx_d = cnt_d;
      end
      S_DI_LAST: begin
        vld_d  = 1'b1;
        last_d = 1'b1;
        idx_d  = di_blk_s;
        pad_d  = di_pad_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      blk_valid_o   <= 1'b0;
      blk_is_ad_o   <= 1'b0;
      blk_last_o    <= 1'b0;
      blk_idx_o     <= '0;
      blk_pad_idx_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      blk_valid_o   <= vld_d;
      blk_is_ad_o   <= is_ad_d;
      blk_last_o    <= last_d;
      blk_idx_o     <= idx_d;
      blk_pad_idx_o <= pad_d;
      busy_o        <= (state_d != S_IDLE);
      done_o        <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ad_blk_q <= '0;
      ad_pad_q <= '0;
      di_blk_q <= '0;
      di_pad_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      ad_blk_q <= ad_blk_no_i;
      ad_pad_q <= ad_pad_idx_i;
      di_blk_q <= di_blk_no_i;
      di_pad_q <= di_pad_idx_i;
    end
  end

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Directed bench for ascon_block_sequencer; descriptors packed as {valid, is_ad, last, idx[7:0], pad[3:0]}.
module tb_ascon_block_sequencer;

  localparam int BLOCK_AW = 8;
  localparam int PAD_AW   = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                start_i;
  logic [BLOCK_AW-1:0] ad_blk_no_i;
  logic [PAD_AW-1:0]   ad_pad_idx_i;
  logic                ad_empty_i;
  logic [BLOCK_AW-1:0] di_blk_no_i;
  logic [PAD_AW-1:0]   di_pad_idx_i;
  logic                abort_i;
  logic                blk_ready_i;
  logic                blk_valid_o;
  logic                blk_is_ad_o;
  logic                blk_last_o;
  logic [BLOCK_AW-1:0] blk_idx_o;
  logic [PAD_AW-1:0]   blk_pad_idx_o;
  logic                busy_o;
  logic                done_o;

  int errs   = 0;
  int checks = 0;

  ascon_block_sequencer #(.BLOCK_AW(BLOCK_AW), .PAD_AW(PAD_AW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .ad_blk_no_i   (ad_blk_no_i),
    .ad_pad_idx_i  (ad_pad_idx_i),
    .ad_empty_i    (ad_empty_i),
    .di_blk_no_i   (di_blk_no_i),
    .di_pad_idx_i  (di_pad_idx_i),
`ifdef ASCON_SEQ_ABORT_EN
    .abort_i       (abort_i),
`endif
    .blk_ready_i   (blk_ready_i),
    .blk_valid_o   (blk_valid_o),
    .blk_is_ad_o   (blk_is_ad_o),
    .blk_last_o    (blk_last_o),
    .blk_idx_o     (blk_idx_o),
    .blk_pad_idx_o (blk_pad_idx_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [14:0] d(input logic v, input logic a, input logic l,
                                    input logic [7:0] idx, input logic [3:0] pad);
    return {v, a, l, idx, pad};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(input string tag, input logic [14:0] exp);
    chk(tag, {17'd0, blk_valid_o, blk_is_ad_o, blk_last_o, blk_idx_o, blk_pad_idx_o}, {17'd0, exp});
  endtask

  // {valid, busy, done}
  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, blk_valid_o, busy_o, done_o}, {29'd0, exp});
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  logic [14:0] exp4 [5];
  int          nfull, bad, lastidx, seen;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; ad_blk_no_i = '0; ad_pad_idx_i = '0; ad_empty_i = 1'b0;
    di_blk_no_i = '0; di_pad_idx_i = '0; abort_i = 1'b0; blk_ready_i = 1'b1;
    step();
    chk_desc("reset_desc", d(0, 0, 0, 8'd0, 4'd0));
    chk_st("reset_st", 3'b000);
    rst_ni = 1'b1;
    step();
    chk_st("idle_ready_no_effect", 3'b000);

    // 1: ad 2 full + pad 5, data 1 full + pad 0
    ad_blk_no_i = 8'd2; ad_pad_idx_i = 4'd5; di_blk_no_i = 8'd1; di_pad_idx_i = 4'd0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    ad_blk_no_i = 8'd9; ad_pad_idx_i = 4'd14; di_blk_no_i = 8'd7; di_pad_idx_i = 4'd11;
    chk_desc("t1_ad0", d(1, 1, 0, 8'd0, 4'd0));
    chk_st("t1_busy", 3'b110);
    step(); chk_desc("t1_ad1", d(1, 1, 0, 8'd1, 4'd0));
    step(); chk_desc("t1_adlast", d(1, 1, 1, 8'd2, 4'd5));
    step(); chk_desc("t1_di0", d(1, 0, 0, 8'd0, 4'd0));
    step(); chk_desc("t1_dilast", d(1, 0, 1, 8'd1, 4'd0));
    step(); chk_st("t1_done", 3'b011);
    step(); chk_st("t1_idle", 3'b000);

    // 2: AD empty, zero data -> single padding-only data block
    ad_empty_i = 1'b1; di_blk_no_i = 8'd0; di_pad_idx_i = 4'd0; start_i = 1'b1;
    step();
    start_i = 1'b0; ad_empty_i = 1'b0;
    chk_desc("t2_dilast", d(1, 0, 1, 8'd0, 4'd0));
    step(); chk_st("t2_done", 3'b011);

    // 3: start held from the DONE cycle; honoured in the following IDLE cycle
    ad_blk_no_i = 8'd0; ad_pad_idx_i = 4'd3; di_blk_no_i = 8'd0; di_pad_idx_i = 4'd7; start_i = 1'b1;
    step(); chk_st("t3_idle_between", 3'b000);
    step();
    start_i = 1'b0;
    chk_desc("t3_adlast", d(1, 1, 1, 8'd0, 4'd3));
    step(); chk_desc("t3_dilast", d(1, 0, 1, 8'd0, 4'd7));
    step(); chk_st("t3_done", 3'b011);
    step(); chk_st("t3_idle", 3'b000);

    // 4: ready toggles every cycle, stray start pulses mid-run
    exp4[0] = d(1, 1, 0, 8'd0, 4'd0);
    exp4[1] = d(1, 1, 0, 8'd1, 4'd0);
    exp4[2] = d(1, 1, 0, 8'd2, 4'd0);
    exp4[3] = d(1, 1, 1, 8'd3, 4'd1);
    exp4[4] = d(1, 0, 1, 8'd0, 4'd2);
    ad_blk_no_i = 8'd3; ad_pad_idx_i = 4'd1; di_blk_no_i = 8'd0; di_pad_idx_i = 4'd2;
    blk_ready_i = 1'b0; start_i = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk_desc($sformatf("t4_desc%0d", k), exp4[k]);
      blk_ready_i = 1'b0; start_i = 1'b0;
      step();
      chk_desc($sformatf("t4_hold%0d", k), exp4[k]);
      blk_ready_i = 1'b1; start_i = (k % 2 == 1);
      step();
    end
    start_i = 1'b0; blk_ready_i = 1'b0;
    chk_st("t4_done", 3'b011);
    step(); chk_st("t4_idle", 3'b000);
    step(); chk_st("t4_no_restart", 3'b000);

    // 5: reset in DI_FULL, then a clean rerun from idx0
    blk_ready_i = 1'b1; ad_empty_i = 1'b1; di_blk_no_i = 8'd3; di_pad_idx_i = 4'd4; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_desc("t5_di0", d(1, 0, 0, 8'd0, 4'd0));
    step(); chk_desc("t5_di1", d(1, 0, 0, 8'd1, 4'd0));
    #2 rst_ni = 1'b0;
    #1 chk_desc("t5_async_desc", d(0, 0, 0, 8'd0, 4'd0));
    chk_st("t5_async_st", 3'b000);
    step();
    rst_ni = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_desc("t5_re_di0", d(1, 0, 0, 8'd0, 4'd0));
    step(); chk_desc("t5_re_di1", d(1, 0, 0, 8'd1, 4'd0));
    step(); chk_desc("t5_re_di2", d(1, 0, 0, 8'd2, 4'd0));
    step(); chk_desc("t5_re_dilast", d(1, 0, 1, 8'd3, 4'd4));
    step(); chk_st("t5_done", 3'b011);
    step(); ad_empty_i = 1'b0;

    // Max block count: 255 full data blocks, no wrap
    ad_empty_i = 1'b1; di_blk_no_i = 8'hFF; di_pad_idx_i = 4'd9; start_i = 1'b1;
    step();
    start_i = 1'b0; ad_empty_i = 1'b0;
    nfull = 0; bad = 0; lastidx = -1; seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (done_o) begin
        seen = 1;
        break;
      end
      if (blk_valid_o) begin
        if (!blk_last_o) begin
          if (int'(blk_idx_o) != nfull) bad++;
          nfull++;
        end else begin
          lastidx = int'(blk_idx_o);
        end
      end
      step();
    end
    chk("max_done_seen", seen, 1);
    chk("max_full_count", nfull, 255);
    chk("max_idx_seq_errors", bad, 0);
    chk("max_last_idx", lastidx, 255);
    step(); chk_st("max_idle", 3'b000);

`ifdef ASCON_SEQ_ABORT_EN
    // 6: abort during AD_LAST wins over a coincident handshake
    ad_blk_no_i = 8'd0; ad_pad_idx_i = 4'd6; di_blk_no_i = 8'd0; di_pad_idx_i = 4'd0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_desc("t6_adlast", d(1, 1, 1, 8'd0, 4'd6));
    abort_i = 1'b1; blk_ready_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk_st("t6_aborted", 3'b000);
    step(); chk_st("t6_no_done", 3'b000);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
